// File: rtl/fetch_unit.sv
// fetch_unit: MIPS IF stage holding the PC, the IF/ID register and a fetch counter, with stall and redirect.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [15:0] branch_imm,
  input  logic        jump,
  input  logic [25:0] jump_target,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valid,
  output logic [31:0] fetch_count
);
  logic [31:0] pc_q, pc_d, instr_q, instr_d, pc4_q, pc4_d, cnt_q, cnt_d;
  logic        valid_q, valid_d;
  logic [31:0] pc_plus4, br_tgt, j_tgt;
  logic        do_j, do_b, flush, fetch;
  // redirects only count when IF/ID holds a real instruction; a bubble cannot redirect
  assign do_j     = jump & valid_q;
  assign do_b     = branch_taken & valid_q;
  assign flush    = do_j | do_b;
  assign fetch    = ~flush & ~stall;
  assign pc_plus4 = pc_q + 32'd4;
  assign br_tgt   = pc4_q + {{14{branch_imm[15]}}, branch_imm, 2'b00};
  assign j_tgt    = {pc4_q[31:28], jump_target, 2'b00};
  always_comb begin
    pc_d    = do_j ? j_tgt : do_b ? br_tgt : fetch ? pc_plus4 : pc_q;
    instr_d = flush ? 32'd0 : fetch ? imem_data : instr_q;
    pc4_d   = flush ? 32'd0 : fetch ? pc_plus4 : pc4_q;
    valid_d = flush ? 1'b0 : fetch ? 1'b1 : valid_q;
    cnt_d   = fetch ? cnt_q + 32'd1 : cnt_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q    <= RESET_PC;
      instr_q <= 32'd0;
      pc4_q   <= 32'd0;
      valid_q <= 1'b0;
      cnt_q   <= 32'd0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end
  assign imem_addr   = pc_q;
  assign if_id_instr = instr_q;
  assign if_id_pc4   = pc4_q;
  assign if_id_valid = valid_q;
  assign fetch_count = cnt_q;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed vectors push expected IF state into a queue; a negedge monitor pops and compares.
module tb_fetch_unit;
  logic        clk = 1'b0;
  logic        rst_n, stall, branch_taken, jump;
  logic [15:0] branch_imm;
  logic [25:0] jump_target;
  logic [31:0] imem_addr, imem_data, if_id_instr, if_id_pc4, fetch_count;
  logic        if_id_valid;
  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        v;
    logic [31:0] cnt;
    int          id;
  } exp_t;
  exp_t exp_q[$];
  int errors = 0;
  int checks = 0;
  always #5 clk = ~clk;
  // memory word at A is addi-like with A[15:0] as its immediate, so the bench knows every fetched word
  assign imem_data = {16'h2008, imem_addr[15:0]};
  fetch_unit #(.RESET_PC(32'h0)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .branch_taken(branch_taken),
    .branch_imm(branch_imm), .jump(jump), .jump_target(jump_target),
    .imem_addr(imem_addr), .imem_data(imem_data), .if_id_instr(if_id_instr),
    .if_id_pc4(if_id_pc4), .if_id_valid(if_id_valid), .fetch_count(fetch_count)
  );
  task automatic check(input string name, input int id, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %h expected %h", name, id, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("imem_addr", e.id, imem_addr, e.pc);
      check("if_id_instr", e.id, if_id_instr, e.instr);
      check("if_id_pc4", e.id, if_id_pc4, e.pc4);
      check("if_id_valid", e.id, {31'd0, if_id_valid}, {31'd0, e.v});
      check("fetch_count", e.id, fetch_count, e.cnt);
    end
  end
  int step_no = 0;
  task automatic step(input logic rn, input logic s, input logic b, input logic [15:0] im,
                      input logic jj, input logic [25:0] jt, input logic [31:0] epc,
                      input logic [31:0] ei, input logic [31:0] ep4, input logic ev, input logic [31:0] ec);
    exp_t e;
    rst_n = rn; stall = s; branch_taken = b; branch_imm = im; jump = jj; jump_target = jt;
    @(posedge clk);
    #1;
    step_no++;
    e.pc = epc; e.instr = ei; e.pc4 = ep4; e.v = ev; e.cnt = ec; e.id = step_no;
    exp_q.push_back(e);
  endtask
  task automatic norm(input logic [31:0] epc, input logic [31:0] ei, input logic [31:0] ep4, input logic [31:0] ec);
    step(1, 0, 0, 16'h0, 0, 26'h0, epc, ei, ep4, 1, ec);
  endtask
  task automatic jmp(input logic [25:0] jt, input logic [31:0] epc, input logic [31:0] ec);
    step(1, 0, 0, 16'h0, 1, jt, epc, 0, 0, 0, ec);
  endtask
  initial begin
    step(0, 0, 0, 16'h0, 0, 26'h0, 32'h0, 0, 0, 0, 0);
    norm(32'h4, 32'h20080000, 32'h4, 1);
    norm(32'h8, 32'h20080004, 32'h8, 2);
    norm(32'hC, 32'h20080008, 32'hC, 3);
    step(1, 0, 1, 16'h0020, 0, 26'h0, 32'h8C, 0, 0, 0, 3);
    step(1, 0, 1, 16'h0020, 0, 26'h0, 32'h90, 32'h2008008C, 32'h90, 1, 4);
    step(1, 0, 1, 16'hFFE3, 0, 26'h0, 32'h1C, 0, 0, 0, 4);
    norm(32'h20, 32'h2008001C, 32'h20, 5);
    step(1, 0, 1, 16'hFFFE, 0, 26'h0, 32'h18, 0, 0, 0, 5);
    norm(32'h1C, 32'h20080018, 32'h1C, 6);
    step(1, 0, 1, 16'hFFF8, 0, 26'h0, 32'hFFFFFFFC, 0, 0, 0, 6);
    norm(32'h0, 32'h2008FFFC, 32'h0, 7);
    jmp(26'h3FFFFFF, 32'h0FFFFFFC, 7);
    norm(32'h10000000, 32'h2008FFFC, 32'h10000000, 8);
    jmp(26'h3FFFFFF, 32'h1FFFFFFC, 8);
    norm(32'h20000000, 32'h2008FFFC, 32'h20000000, 9);
    jmp(26'h3FFFFFF, 32'h2FFFFFFC, 9);
    norm(32'h30000000, 32'h2008FFFC, 32'h30000000, 10);
    jmp(26'h3FFFFFF, 32'h3FFFFFFC, 10);
    norm(32'h40000000, 32'h2008FFFC, 32'h40000000, 11);
    jmp(26'h0000003, 32'h4000000C, 11);
    norm(32'h40000010, 32'h2008000C, 32'h40000010, 12);
    step(1, 1, 1, 16'h0020, 1, 26'h0000100, 32'h40000400, 0, 0, 0, 12);
    step(1, 1, 0, 16'h0, 1, 26'h0000100, 32'h40000400, 0, 0, 0, 12);
    norm(32'h40000404, 32'h20080400, 32'h40000404, 13);
    step(0, 1, 0, 16'h0, 1, 26'h0000100, 32'h0, 0, 0, 0, 0);
    norm(32'h4, 32'h20080000, 32'h4, 1);
    norm(32'h8, 32'h20080004, 32'h8, 2);
    norm(32'hC, 32'h20080008, 32'hC, 3);
    norm(32'h10, 32'h2008000C, 32'h10, 4);
    norm(32'h14, 32'h20080010, 32'h14, 5);
    for (int i = 0; i < 3; i++) step(1, 1, 0, 16'h0, 0, 26'h0, 32'h14, 32'h20080010, 32'h14, 1, 5);
    norm(32'h18, 32'h20080014, 32'h18, 6);
    step(1, 1, 0, 16'h0, 0, 26'h0, 32'h18, 32'h20080014, 32'h18, 1, 6);
    step(0, 1, 0, 16'h0, 0, 26'h0, 32'h0, 0, 0, 0, 0);
    step(1, 1, 0, 16'h0, 0, 26'h0, 32'h0, 0, 0, 0, 0);
    norm(32'h4, 32'h20080000, 32'h4, 1);
    norm(32'h8, 32'h20080004, 32'h8, 2);
    stall = 1'b1;
    for (int i = 0; i < 4 && exp_q.size() != 0; i++) @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected entries left unchecked, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
